// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the pipelined RISC-V core.
//            Fetch FSM state encoding, the bubble instruction word and the
//            default reset PC.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Opcode 7'b0000000 decodes to all-zero controls, so this word is inert.
  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    KILL  = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register. Clear has priority over enable; when
//            enabled without a load it captures a bubble.
// Ports    : clk, reset   - clock, async active-high reset
//            i_en         - advance (hold when low)
//            i_clr        - load bubble, keep PC fields
//            i_load       - real instruction available
//            i_instr/i_pc/i_pcplus4 - data to capture
//            o_instr/o_pc/o_pcplus4/o_valid - register contents
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_en,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pcplus4,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcplus4,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcplus4;
  logic            r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr   <= '0;
      r_pc      <= '0;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else if (i_clr) begin
      r_instr <= NOP_BUBBLE;
      r_valid <= 1'b0;
    end else if (i_en) begin
      if (i_load) begin
        r_instr   <= i_instr;
        r_pc      <= i_pc;
        r_pcplus4 <= i_pcplus4;
        r_valid   <= 1'b1;
      end else begin
        r_instr <= NOP_BUBBLE;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pcplus4 = r_pcplus4;
  assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch. Owns PCF, issues imem requests over a
//            req/ready handshake, holds one response in a skid buffer while
//            decode stalls, and drains an in-flight request (KILL) when an
//            EX redirect arrives mid-request.
// Ports    : clk, reset            - clock, async active-high reset
//            StallD, FlushD        - hazard unit hold / bubble for IF/ID
//            PCSrcE, PCTargetE     - EX redirect and its target
//            ImemReq, ImemAddr     - fetch request / address
//            ImemRdata, ImemReady  - instruction word / accept strobe
//            InstrD, PCD, PCPlus4D, ValidD - IF/ID register
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic [31:0]     ImemRdata,
  input  logic            ImemReady,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_t    r_state,     w_state_next;
  logic [XLEN-1:0] r_pcf,       w_pcf_next;
  logic [XLEN-1:0] r_redir,     w_redir_next;
  logic [31:0]     r_buf_instr, w_buf_instr_next;
  logic [XLEN-1:0] r_buf_pc,    w_buf_pc_next;
  logic            r_buf_valid, w_buf_valid_next;

  logic            w_req;
  logic            w_accept;
  logic            w_avail;
  logic [31:0]     w_ld_instr;
  logic [XLEN-1:0] w_ld_pc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= FETCH;
      r_pcf       <= RESET_PC;
      r_redir     <= '0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
      r_buf_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pcf       <= w_pcf_next;
      r_redir     <= w_redir_next;
      r_buf_instr <= w_buf_instr_next;
      r_buf_pc    <= w_buf_pc_next;
      r_buf_valid <= w_buf_valid_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next     = r_state;
    w_pcf_next       = r_pcf;
    w_redir_next     = r_redir;
    w_buf_instr_next = r_buf_instr;
    w_buf_pc_next    = r_buf_pc;
    w_buf_valid_next = r_buf_valid;
    case (r_state)
      FETCH: begin
        if (PCSrcE) begin
          // Redirect overrides PCF/buffer updates; the same-cycle response
          // (if any) is for the wrong path and is not counted.
          w_buf_valid_next = 1'b0;
          if (w_req && !ImemReady) begin
            w_redir_next = PCTargetE;
            w_state_next = KILL;
          end else begin
            w_pcf_next = PCTargetE;
          end
        end else begin
          if (w_accept) begin
            w_pcf_next = r_pcf + XLEN'(4);
          end
          // w_accept implies the buffer is empty, since req drops when full.
          if (StallD && w_accept) begin
            w_buf_instr_next = ImemRdata;
            w_buf_pc_next    = r_pcf;
            w_buf_valid_next = 1'b1;
          end else if (!StallD && r_buf_valid) begin
            w_buf_valid_next = 1'b0;
          end
        end
      end
      KILL: begin
        if (PCSrcE) begin
          // Latest redirect wins, even when it coincides with the drain.
          if (ImemReady) begin
            w_pcf_next   = PCTargetE;
            w_state_next = FETCH;
          end else begin
            w_redir_next = PCTargetE;
          end
        end else if (ImemReady) begin
          w_pcf_next   = r_redir;
          w_state_next = FETCH;
        end
      end
      default: w_state_next = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    w_req      = (r_state == KILL) || !r_buf_valid;
    w_accept   = (r_state == FETCH) && w_req && ImemReady;
    w_avail    = r_buf_valid || w_accept;
    w_ld_instr = r_buf_valid ? r_buf_instr : ImemRdata;
    w_ld_pc    = r_buf_valid ? r_buf_pc    : r_pcf;
  end

  assign ImemReq  = w_req;
  assign ImemAddr = r_pcf;

  if_id_reg #(
    .XLEN (XLEN)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .i_en      (!StallD),
    .i_clr     (FlushD),
    .i_load    (w_avail),
    .i_instr   (w_ld_instr),
    .i_pc      (w_ld_pc),
    .i_pcplus4 (w_ld_pc + XLEN'(4)),
    .o_instr   (InstrD),
    .o_pc      (PCD),
    .o_pcplus4 (PCPlus4D),
    .o_valid   (ValidD)
  );

endmodule
`default_nettype wire
